// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer. It generates the frame tick, arbitrates the serve,
// holds or releases the ball, and keeps the scores and the winner.
module pong_match_ctrl #(
    parameter int FRAME_DIV  = 833333,
    parameter int SERVE_HOLD = 30,
    parameter int POINT_HOLD = 60,
    parameter int WIN_SCORE  = 7,
    parameter int SCORE_W    = 3
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               serve_p1,
    input  logic               serve_p2,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               tick,
    output logic               ball_home,
    output logic               ball_run,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         winner,
    output logic [2:0]         state
);
    localparam int DIV_W    = $clog2(FRAME_DIV) > 0 ? $clog2(FRAME_DIV) : 1;
    localparam int HOLD_MAX = SERVE_HOLD > POINT_HOLD ? SERVE_HOLD : POINT_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_MAX) > 0 ? $clog2(HOLD_MAX) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [HOLD_W-1:0]  SERVE_LAST = HOLD_W'(SERVE_HOLD - 1);
    localparam logic [HOLD_W-1:0]  POINT_LAST = HOLD_W'(POINT_HOLD - 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    logic [DIV_W-1:0]   r_div;
    state_t             r_state, w_next;
    logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic [SCORE_W-1:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt;
    logic [1:0]         r_winner, w_win_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_home, r_run, w_home, w_run;
    logic               w_tick;

    assign w_tick = r_div == DIV_LAST;

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            r_div <= '0;
        else
            r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_winner <= 2'b00;
            r_dir    <= 1'b1;
            r_home   <= 1'b1;
            r_run    <= 1'b0;
        end else if (w_tick) begin
            r_state  <= w_next;
            r_hold   <= w_hold_nxt;
            r_p1     <= w_p1_nxt;
            r_p2     <= w_p2_nxt;
            r_winner <= w_win_nxt;
            r_dir    <= w_dir_nxt;
            r_home   <= w_home;
            r_run    <= w_run;
        end
    end

    // Hold counts up by default; every state that leads into a timed hold clears it first.
    always_comb begin
        w_next     = r_state;
        w_hold_nxt = r_hold + 1'b1;
        w_p1_nxt   = r_p1;
        w_p2_nxt   = r_p2;
        w_win_nxt  = r_winner;
        w_dir_nxt  = r_dir;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (serve_p1 || serve_p2) begin
                    w_dir_nxt = serve_p1;
                    w_next    = SERVE;
                end
            end
            SERVE: w_next = (r_hold == SERVE_LAST) ? PLAY : SERVE;
            PLAY: begin
                w_hold_nxt = '0;
                w_next     = (miss_left || miss_right) ? POINT : PLAY;
                w_p2_nxt   = (miss_left && !miss_right && r_p2 != WIN) ? r_p2 + 1'b1 : r_p2;
                w_p1_nxt   = (miss_right && !miss_left && r_p1 != WIN) ? r_p1 + 1'b1 : r_p1;
            end
            POINT: begin
                if (r_hold == POINT_LAST) begin
                    w_win_nxt = (r_p1 == WIN) ? 2'b01 : (r_p2 == WIN) ? 2'b10 : 2'b00;
                    w_next    = (r_p1 == WIN || r_p2 == WIN) ? OVER : IDLE;
                end
            end
            OVER: begin
                w_hold_nxt = '0;
                if (serve_p1 || serve_p2) begin
                    w_next    = IDLE;
                    w_p1_nxt  = '0;
                    w_p2_nxt  = '0;
                    w_win_nxt = 2'b00;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Ball controls are registered from the next state so they change together with it.
    always_comb begin
        w_home = w_next != PLAY;
        w_run  = w_next == PLAY;
    end

    assign tick      = w_tick;
    assign ball_home = r_home;
    assign ball_run  = r_run;
    assign serve_dir = r_dir;
    assign p1_score  = r_p1;
    assign p2_score  = r_p2;
    assign winner    = r_winner;
    assign state     = r_state;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed test-plan steps followed by random play, all checked every cycle
// against a tick-level reference model of the match rules.
module tb_pong_match_ctrl;
    localparam int FD = 4, SH = 2, PH = 3, WS = 3, SW = 3;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1;
    logic serve_p1 = 1'b0, serve_p2 = 1'b0, miss_left = 1'b0, miss_right = 1'b0;
    logic tick, ball_home, ball_run, serve_dir;
    logic [SW-1:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    int tests = 0, fails = 0;
    int m_ph, m_st, m_rem, m_p1, m_p2, m_win, m_dir;

    always #10 CLOCK_50 = ~CLOCK_50;

    pong_match_ctrl #(
        .FRAME_DIV(FD), .SERVE_HOLD(SH), .POINT_HOLD(PH), .WIN_SCORE(WS), .SCORE_W(SW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .serve_p1(serve_p1), .serve_p2(serve_p2),
        .miss_left(miss_left), .miss_right(miss_right),
        .tick(tick), .ball_home(ball_home), .ball_run(ball_run), .serve_dir(serve_dir),
        .p1_score(p1_score), .p2_score(p2_score), .winner(winner), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_st = 0; m_rem = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1;
    endtask

    // One game frame of the match rules; m_rem counts the frames still to wait in a hold.
    task automatic model_tick(input bit s1, input bit s2, input bit ml, input bit mr);
        case (m_st)
            0: if (s1 || s2) begin m_dir = s1 ? 1 : 0; m_st = 1; m_rem = SH; end
            1: begin m_rem--; if (m_rem == 0) m_st = 2; end
            2: begin
                if (ml && !mr && m_p2 < WS) m_p2++;
                if (mr && !ml && m_p1 < WS) m_p1++;
                if (ml || mr) begin m_st = 3; m_rem = PH; end
            end
            3: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_win = (m_p1 == WS) ? 1 : (m_p2 == WS) ? 2 : 0;
                    m_st = (m_win != 0) ? 4 : 0;
                end
            end
            4: if (s1 || s2) begin m_p1 = 0; m_p2 = 0; m_win = 0; m_st = 0; end
            default: ;
        endcase
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        if (reset) model_reset();
        else begin
            if (m_ph == FD - 1) model_tick(serve_p1, serve_p2, miss_left, miss_right);
            m_ph = (m_ph + 1) % FD;
        end
        #1;
        chk("tick", 32'(tick), (m_ph == FD - 1) ? 1 : 0);
        chk("state", 32'(state), m_st);
        chk("ball_home", 32'(ball_home), (m_st != 2) ? 1 : 0);
        chk("ball_run", 32'(ball_run), (m_st == 2) ? 1 : 0);
        chk("serve_dir", 32'(serve_dir), m_dir);
        chk("p1_score", 32'(p1_score), m_p1);
        chk("p2_score", 32'(p2_score), m_p2);
        chk("winner", 32'(winner), m_win);
    endtask

    task automatic tick_step();
        while (m_ph != FD - 1) cyc();
        cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_step();
    endtask

    initial begin
        model_reset();
        repeat (3) cyc();
        reset = 1'b0;
        chk("plan1_tick_c1", 32'(tick), 0);
        for (int n = 2; n <= 13; n++) begin
            cyc();
            chk("plan1_tick", 32'(tick), (n % FD == 0) ? 1 : 0);
        end
        chk("plan1_state", 32'(state), 0);
        chk("plan1_home", 32'(ball_home), 1);
        chk("plan1_p1", 32'(p1_score), 0);

        serve_p1 = 1'b1; tick_step(); serve_p1 = 1'b0;
        chk("plan2_state_serve", 32'(state), 1);
        chk("plan2_dir", 32'(serve_dir), 1);
        ticks(2);
        chk("plan2_state_play", 32'(state), 2);
        chk("plan2_run", 32'(ball_run), 1);
        chk("plan2_home", 32'(ball_home), 0);

        miss_right = 1'b1; tick_step(); miss_right = 1'b0;
        chk("plan3_p1", 32'(p1_score), 1);
        chk("plan3_state_point", 32'(state), 3);
        ticks(3);
        chk("plan3_state_idle", 32'(state), 0);
        serve_p2 = 1'b1; tick_step(); serve_p2 = 1'b0;
        chk("plan3_dir", 32'(serve_dir), 0);
        ticks(2);
        chk("plan3_state_play", 32'(state), 2);

        miss_left = 1'b1; miss_right = 1'b1; tick_step(); miss_left = 1'b0; miss_right = 1'b0;
        chk("plan4_p1", 32'(p1_score), 1);
        chk("plan4_p2", 32'(p2_score), 0);
        chk("plan4_state_point", 32'(state), 3);
        ticks(3);
        chk("plan4_state_idle", 32'(state), 0);

        repeat (3) begin
            serve_p2 = 1'b1; tick_step(); serve_p2 = 1'b0;
            ticks(2);
            miss_left = 1'b1; tick_step(); miss_left = 1'b0;
            ticks(3);
        end
        chk("plan5_winner", 32'(winner), 2);
        chk("plan5_state_over", 32'(state), 4);
        chk("plan5_p2", 32'(p2_score), 3);
        miss_left = 1'b1; miss_right = 1'b1; ticks(2); miss_left = 1'b0; miss_right = 1'b0;
        chk("plan5_over_p1", 32'(p1_score), 1);
        chk("plan5_over_p2", 32'(p2_score), 3);
        chk("plan5_over_state", 32'(state), 4);
        serve_p1 = 1'b1; tick_step(); serve_p1 = 1'b0;
        chk("plan5_clr_p1", 32'(p1_score), 0);
        chk("plan5_clr_p2", 32'(p2_score), 0);
        chk("plan5_clr_winner", 32'(winner), 0);
        chk("plan5_clr_state", 32'(state), 0);

        serve_p1 = 1'b1; serve_p2 = 1'b1; tick_step(); serve_p1 = 1'b0; serve_p2 = 1'b0;
        chk("plan6_dir", 32'(serve_dir), 1);
        ticks(2);
        repeat (2) begin
            miss_right = 1'b1; tick_step(); miss_right = 1'b0;
            ticks(3);
            serve_p1 = 1'b1; tick_step(); serve_p1 = 1'b0;
            ticks(2);
        end
        chk("plan6_p1_pre", 32'(p1_score), 2);
        chk("plan6_state_pre", 32'(state), 2);
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("plan6_rst_state", 32'(state), 0);
        chk("plan6_rst_p1", 32'(p1_score), 0);
        chk("plan6_rst_tick", 32'(tick), 0);
        for (int n = 2; n <= 5; n++) begin
            cyc();
            chk("plan6_tick", 32'(tick), (n == 4) ? 1 : 0);
        end

        repeat (3000) begin
            serve_p1   = ($urandom_range(0, 11) == 0);
            serve_p2   = ($urandom_range(0, 11) == 0);
            miss_left  = ($urandom_range(0, 5) == 0);
            miss_right = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 799) == 0);
            cyc();
        end
        reset = 1'b0; serve_p1 = 1'b0; serve_p2 = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
